// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants for all display blocks, plus the
// counter type and a window-decode helper used by the timing generator.
package vga_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // Half-open window test: lo <= v < hi, unsigned.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Divides CLK into a one-cycle PIX_CE pulse every CE_DIV cycles. TICK is the
// unregistered "pulse next edge" condition so the raster can move on that same edge.
module pix_ce_gen #(
    parameter int CE_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    output logic PIX_CE,
    output logic TICK
);

    localparam int CW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);

    logic [CW-1:0] ce_cnt_q;
    logic          pix_ce_q;

    assign TICK   = (ce_cnt_q == CNT_LAST);
    assign PIX_CE = pix_ce_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ce_cnt_q <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            ce_cnt_q <= TICK ? '0 : ce_cnt_q + 1'b1;
            pix_ce_q <= TICK;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters and sync/blank decode for VGA timing, advanced by the pixel
// enable from pix_ce_gen. Decodes are taken from next-count values so they line up with PIX_X/PIX_Y.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CE_DIV = 4,
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       PIX_CE,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       LINE_START,
    output logic       FRAME_START
);

    localparam int   H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
    localparam cnt_t HS_LO   = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_HI   = cnt_t'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t VS_LO   = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_HI   = cnt_t'(V_VIS + V_FP + V_SYNC);

    logic tick;
    cnt_t x_q, x_d, y_q, y_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;

    pix_ce_gen #(.CE_DIV(CE_DIV)) u_pix_ce_gen (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .PIX_CE (PIX_CE),
        .TICK   (tick)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        hsync_d       = !in_window(x_d, HS_LO, HS_HI);
        vsync_d       = !in_window(y_d, VS_LO, VS_HI);
        video_on_d    = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        line_start_d  = tick && (x_q == H_LAST);
        frame_start_d = line_start_d && (y_q == V_LAST);
    end

    // Preloading the last raster position makes the first enable land on (0,0).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_X       = x_q;
    assign PIX_Y       = y_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign VIDEO_ON    = video_on_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a tiny-raster instance
// (so whole frames fit in a short run), both checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       ce;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } vout_t;

    typedef struct {
        int    t;
        vout_t o;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ce0, hs0, vs0, vid0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       ce1, hs1, vs1, vid1, ls1, fs1;
    logic [9:0] x1, y1;
    vout_t      a0, a1;
    assign a0 = {ce0, hs0, vs0, vid0, ls0, fs0, x0, y0};
    assign a1 = {ce1, hs1, vs1, vid1, ls1, fs1, x1, y1};

    vga_timing_gen dut0 (
        .CLK(clk), .RST_N(rst_n), .PIX_CE(ce0), .HSYNC(hs0), .VSYNC(vs0),
        .VIDEO_ON(vid0), .PIX_X(x0), .PIX_Y(y0), .LINE_START(ls0), .FRAME_START(fs0)
    );

    // 15x10 raster, CE every 2 clocks: one frame is 300 clocks.
    vga_timing_gen #(
        .CE_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut1 (
        .CLK(clk), .RST_N(rst_n), .PIX_CE(ce1), .HSYNC(hs1), .VSYNC(vs1),
        .VIDEO_ON(vid1), .PIX_X(x1), .PIX_Y(y1), .LINE_START(ls1), .FRAME_START(fs1)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int t_rel    = 0;
    int s_ce0, s_hslow0, s_ls0, s_firsths0;
    int s_fs1, s_vslow1, s_vid1;

    // Raster position from elapsed clocks since reset release: CE on every
    // multiple of cd, the n-th CE showing linear pixel index n-1.
    function automatic vout_t model(int t, int cd, int hv, int hf, int hsw, int hb,
                                    int vv, int vf, int vsw, int vb);
        vout_t r;
        int ht, vt, n, p, x, y;
        logic ce;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        n  = t / cd;
        if (n == 0) begin
            x = ht - 1; y = vt - 1; ce = 1'b0;
        end else begin
            p  = (n - 1) % (ht * vt);
            x  = p % ht;
            y  = p / ht;
            ce = (t % cd) == 0;
        end
        r.ce  = ce;
        r.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
        r.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
        r.vid = (x < hv) && (y < vv);
        r.ls  = ce && (x == 0);
        r.fs  = ce && (x == 0) && (y == 0);
        r.x   = 10'(x);
        r.y   = 10'(y);
        return r;
    endfunction

    task automatic cmp(string name, vout_t act, vout_t exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got ce=%b hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d, need ce=%b hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d",
                     name, t_rel, act.ce, act.hs, act.vs, act.vid, act.ls, act.fs, act.x, act.y,
                     exp.ce, exp.hs, exp.vs, exp.vid, exp.ls, exp.fs, exp.x, exp.y);
        end
    endtask

    task automatic cmp_int(string name, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic check_both(string tag);
        cmp({tag, "/dut0"}, a0, model(t_rel, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        cmp({tag, "/dut1"}, a1, model(t_rel, 2, 8, 2, 3, 2, 6, 1, 2, 1));
    endtask

    task automatic clear_stats();
        s_ce0 = 0; s_hslow0 = 0; s_ls0 = 0; s_firsths0 = -1;
        s_fs1 = 0; s_vslow1 = 0; s_vid1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) t_rel++;
        else       t_rel = 0;
        check_both("model");
        if (ce0) begin
            s_ce0++;
            if (!hs0) begin
                if (s_hslow0 == 0) s_firsths0 = int'(x0);
                s_hslow0++;
            end
            if (ls0) s_ls0++;
        end
        if (ce1) begin
            if (fs1)  s_fs1++;
            if (!vs1) s_vslow1++;
            if (vid1) s_vid1++;
        end
    endtask

    // Asynchronous assert between clock edges, immediate check, hold, release on negedge.
    task automatic do_reset(int hold);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        t_rel = 0;
        check_both("async_rst");
        repeat (hold) step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(int t, int x, int y, logic hs, logic vs, logic vid,
                                logic ls, logic fs, logic ce);
        vec_t v;
        v.t = t;
        v.o = '{ce: ce, hs: hs, vs: vs, vid: vid, ls: ls, fs: fs, x: 10'(x), y: 10'(y)};
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int guard;
        int len;

        tbl[0]  = mk(0,    799, 524, 1, 1, 0, 0, 0, 0);
        tbl[1]  = mk(2,    799, 524, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(4,    0,   0,   1, 1, 1, 1, 1, 1);
        tbl[3]  = mk(5,    0,   0,   1, 1, 1, 0, 0, 0);
        tbl[4]  = mk(8,    1,   0,   1, 1, 1, 0, 0, 1);
        tbl[5]  = mk(2560, 639, 0,   1, 1, 1, 0, 0, 1);
        tbl[6]  = mk(2564, 640, 0,   1, 1, 0, 0, 0, 1);
        tbl[7]  = mk(2628, 656, 0,   0, 1, 0, 0, 0, 1);
        tbl[8]  = mk(3008, 751, 0,   0, 1, 0, 0, 0, 1);
        tbl[9]  = mk(3012, 752, 0,   1, 1, 0, 0, 0, 1);
        tbl[10] = mk(3200, 799, 0,   1, 1, 0, 0, 0, 1);
        tbl[11] = mk(3204, 0,   1,   1, 1, 1, 1, 0, 1);
        tbl[12] = mk(3206, 0,   1,   1, 1, 1, 0, 0, 0);

        clear_stats();
        repeat (10) step();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();

        // Reset, first CE and one full line on the full-size raster.
        for (int i = 0; i < 13; i++) begin
            guard = 0;
            while (t_rel < tbl[i].t && guard < 5000) begin
                step();
                guard++;
            end
            cmp_int($sformatf("vec%0d_time", i), t_rel, tbl[i].t);
            cmp($sformatf("vec%0d", i), a0, tbl[i].o);
            $display("vec %0d t=%0d x=%0d y=%0d hs=%b vid=%b ls=%b fs=%b", i, t_rel, x0, y0, hs0, vid0, ls0, fs0);
        end
        cmp_int("line_ce_count", s_ce0, 801);
        cmp_int("line_hsync_low_ce", s_hslow0, 96);
        cmp_int("line_hsync_first_x", s_firsths0, 656);
        cmp_int("line_start_count", s_ls0, 2);

        // One whole small frame, then the (last,last) -> (0,0) wrap.
        do_reset(3);
        clear_stats();
        repeat (300) step();
        cmp_int("frame_start_count", s_fs1, 1);
        cmp_int("frame_vsync_low_ce", s_vslow1, 30);
        cmp_int("frame_video_on_ce", s_vid1, 48);
        cmp_int("wrap_pre_x", int'(x1), 14);
        cmp_int("wrap_pre_y", int'(y1), 9);
        step();
        step();
        cmp("wrap_corner", a1, '{ce: 1'b1, hs: 1'b1, vs: 1'b1, vid: 1'b1, ls: 1'b1, fs: 1'b1, x: 10'd0, y: 10'd0});
        $display("frame: fs=%0d vslow=%0d vid=%0d wrap x=%0d y=%0d", s_fs1, s_vslow1, s_vid1, x1, y1);

        // Mid-frame reset on the small raster, then the restart sequence.
        guard = 0;
        while (!(x1 == 10'd5 && y1 == 10'd3 && ce1) && guard < 400) begin
            step();
            guard++;
        end
        cmp_int("midframe_reach", guard < 400 ? 1 : 0, 1);
        do_reset(4);
        step();
        step();
        cmp("midframe_restart", a1, '{ce: 1'b1, hs: 1'b1, vs: 1'b1, vid: 1'b1, ls: 1'b1, fs: 1'b1, x: 10'd0, y: 10'd0});
        $display("midframe reset: restart x=%0d y=%0d fs=%b", x1, y1, fs1);

        // Mid-line reset on the full-size raster at PIX_X=300.
        guard = 0;
        while (!(x0 == 10'd300 && y0 == 10'd0) && guard < 2000) begin
            step();
            guard++;
        end
        cmp_int("midline_reach", guard < 2000 ? 1 : 0, 1);
        do_reset(2);
        repeat (4) step();
        cmp("midline_restart", a0, '{ce: 1'b1, hs: 1'b1, vs: 1'b1, vid: 1'b1, ls: 1'b1, fs: 1'b1, x: 10'd0, y: 10'd0});
        $display("midline reset: restart x=%0d y=%0d fs=%b", x0, y0, fs0);

        // Random run lengths with asynchronous resets at random sub-cycle points.
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(20, 1500);
            repeat (len) step();
            $display("random %0d: ran %0d clocks to x0=%0d y0=%0d x1=%0d y1=%0d", it, len, x0, y0, x1, y1);
            do_reset($urandom_range(1, 5));
        end
        repeat (50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
